// File: rtl/down_timer.sv
// Loadable down-counter/timer: counts a captured start value down to zero,
// pulses tc at the terminal step, then stops (one-shot) or reloads (periodic).
module down_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic             auto_rld,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] rld_q, rld_nxt;
  logic             tc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt_out <= '0;
      rld_q   <= '0;
      tc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_out <= cnt_nxt;
      rld_q   <= rld_nxt;
      tc      <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_out;
    rld_nxt   = rld_q;
    tc_nxt    = 1'b0;

    if (load) begin
      // A zero load parks in IDLE so it can never reach a terminal step.
      cnt_nxt   = cnt_in;
      rld_nxt   = cnt_in;
      state_nxt = (cnt_in != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        RUN: begin
          if (enab) begin
            if (cnt_out == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (auto_rld) begin
                cnt_nxt = rld_q;
              end else begin
                cnt_nxt   = '0;
                state_nxt = DONE;
              end
            end else if (cnt_out != '0) begin
              cnt_nxt = cnt_out - WIDTH'(1);
            end
          end
        end
        IDLE, DONE: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; each task drives one scenario
// and compares {cnt_out, tc, busy, done} against hand-computed values.
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic       enab;
  logic       auto_rld;
  logic [4:0] cnt_in;
  logic [4:0] cnt_out;
  logic       tc;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  down_timer #(.WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .enab     (enab),
    .auto_rld (auto_rld),
    .cnt_in   (cnt_in),
    .cnt_out  (cnt_out),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; enab = 1'b1; auto_rld = 1'b0; cnt_in = 5'd7;
    tick();
    tick();
    rst = 1'b0; load = 1'b0; enab = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=0",
               cnt_out, tc, busy, done);
    end
    enab = 1'b1;
    tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_idle_hold: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=0",
               cnt_out, tc, busy, done);
    end
  endtask

  task automatic test_oneshot();
    logic [4:0] exp_cnt [4];
    logic [2:0] exp_fl  [4];
    exp_cnt = '{5'd3, 5'd2, 5'd1, 5'd0};
    exp_fl  = '{3'b010, 3'b010, 3'b010, 3'b101};
    load = 1'b1; cnt_in = 5'd3; auto_rld = 1'b0; enab = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      checks++;
      if ({cnt_out, tc, busy, done} !== {exp_cnt[i], exp_fl[i]}) begin
        errors++;
        $display("FAIL oneshot_step%0d: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=%0d tc/busy/done=%b",
                 i, cnt_out, tc, busy, done, exp_cnt[i], exp_fl[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({cnt_out, tc, busy, done} !== {5'd0, 3'b001}) begin
        errors++;
        $display("FAIL oneshot_hold%0d: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=1",
                 i, cnt_out, tc, busy, done);
      end
    end
  endtask

  task automatic test_periodic();
    logic [4:0] exp_cnt;
    logic       exp_tc;
    load = 1'b1; cnt_in = 5'd2; auto_rld = 1'b1; enab = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd2, 3'b010}) begin
      errors++;
      $display("FAIL periodic_load: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=2 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_cnt = (i % 2 == 0) ? 5'd1 : 5'd2;
      exp_tc  = (i % 2 == 1);
      checks++;
      if ({cnt_out, tc, busy, done} !== {exp_cnt, exp_tc, 2'b10}) begin
        errors++;
        $display("FAIL periodic2_step%0d: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=%0d tc=%b busy=1 done=0",
                 i, cnt_out, tc, busy, done, exp_cnt, exp_tc);
      end
    end
    load = 1'b1; cnt_in = 5'd1;
    tick();
    load = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd1, 3'b010}) begin
      errors++;
      $display("FAIL periodic1_load: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=1 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({cnt_out, tc, busy, done} !== {5'd1, 3'b110}) begin
        errors++;
        $display("FAIL periodic1_step%0d: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=1 tc=1 busy=1 done=0",
                 i, cnt_out, tc, busy, done);
      end
    end
  endtask

  task automatic test_pause_restart();
    logic       en_pat  [4];
    logic [4:0] exp_cnt [4];
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_cnt = '{5'd3, 5'd3, 5'd3, 5'd2};
    load = 1'b1; cnt_in = 5'd4; auto_rld = 1'b0; enab = 1'b0;
    tick();
    load = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd4, 3'b010}) begin
      errors++;
      $display("FAIL pause_load: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=4 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      enab = en_pat[i];
      tick();
      checks++;
      if ({cnt_out, tc, busy, done} !== {exp_cnt[i], 3'b010}) begin
        errors++;
        $display("FAIL pause_step%0d: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=%0d tc=0 busy=1 done=0",
                 i, cnt_out, tc, busy, done, exp_cnt[i]);
      end
    end
    load = 1'b1; cnt_in = 5'd31; enab = 1'b1;
    tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd31, 3'b010}) begin
      errors++;
      $display("FAIL reload_max: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=31 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    load = 1'b0;
    tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd30, 3'b010}) begin
      errors++;
      $display("FAIL max_decrement: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=30 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    load = 1'b1; cnt_in = 5'd0;
    tick();
    load = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b000}) begin
      errors++;
      $display("FAIL load_zero: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=0",
               cnt_out, tc, busy, done);
    end
    tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b000}) begin
      errors++;
      $display("FAIL load_zero_hold: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=0",
               cnt_out, tc, busy, done);
    end
  endtask

  task automatic test_mode_switch();
    // Periodic load, but auto_rld drops before the terminal step: one-shot wins.
    load = 1'b1; cnt_in = 5'd2; auto_rld = 1'b1; enab = 1'b1;
    tick();
    load = 1'b0;
    tick();
    auto_rld = 1'b0;
    tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b101}) begin
      errors++;
      $display("FAIL mode_switch: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=1 busy=0 done=1",
               cnt_out, tc, busy, done);
    end
  endtask

  task automatic test_collisions();
    load = 1'b1; cnt_in = 5'd2; auto_rld = 1'b1; enab = 1'b1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; cnt_in = 5'd5;
    tick();
    load = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd5, 3'b010}) begin
      errors++;
      $display("FAIL load_vs_terminal: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=5 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd1, 3'b010}) begin
      errors++;
      $display("FAIL pre_reset_count: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=1 tc=0 busy=1 done=0",
               cnt_out, tc, busy, done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cnt_out, tc, busy, done} !== {5'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_vs_terminal: got cnt=%0d tc=%b busy=%b done=%b, exp cnt=0 tc=0 busy=0 done=0",
               cnt_out, tc, busy, done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; load = 1'b0; enab = 1'b0; auto_rld = 1'b0; cnt_in = '0;
    #2;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_restart();
    test_mode_switch();
    test_collisions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
